pc_counter: RTL and testbench

- Free-running, enable-gated up-counter used as the processor's program counter.
- Presents the current count on a WIDTH-bit output.
- Advances by INCREMENT on each rising clock edge while enabled.
- Returns to RESET_VALUE on a synchronous clear.

---
 rtl/pc_counter.sv | 45 ++++
 tb/tb_pc_counter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pc_counter.sv
// Program counter: free-running up-counter that advances by INCREMENT while en is high.
// clr synchronously reloads RESET_VALUE and overrides en.
module pc_counter #(
  parameter int unsigned      WIDTH       = 32,
  parameter longint unsigned  INCREMENT   = 1,
  parameter longint unsigned  RESET_VALUE = 0
) (
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             clr,
  input  logic             en
);

  localparam logic [WIDTH-1:0] INC = WIDTH'(INCREMENT);
  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b0;

  // Ripple adder; the carry out of the top bit is dropped so the count wraps.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic q_reg = RST[gi];

      assign sum[gi] = out[gi] ^ INC[gi] ^ carry[gi];

      if (gi < WIDTH - 1) begin : g_carry
        assign carry[gi+1] = (out[gi] & INC[gi]) | (carry[gi] & (out[gi] ^ INC[gi]));
      end

      always_ff @(posedge clk) begin
        if (clr) begin
          q_reg <= RST[gi];
        end else if (en) begin
          q_reg <= sum[gi];
        end
      end

      assign out[gi] = q_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pc_counter.sv
// Self-checking bench for pc_counter: several parameterisations share clr/en and are
// checked against a modular-arithmetic reference model through a scoreboard queue.
module tb_pc_counter;

  localparam int N = 6;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic en  = 1'b1;

  logic [31:0] o0;
  logic [3:0]  o1;
  logic [31:0] o2;
  logic [3:0]  o3;
  logic [31:0] o4;
  logic [7:0]  o5;

  pc_counter #(.WIDTH(32), .INCREMENT(1), .RESET_VALUE(0))
    dut0 (.out(o0), .clk(clk), .clr(clr), .en(en));
  pc_counter #(.WIDTH(4),  .INCREMENT(1), .RESET_VALUE(0))
    dut1 (.out(o1), .clk(clk), .clr(clr), .en(en));
  pc_counter #(.WIDTH(32), .INCREMENT(4), .RESET_VALUE(0))
    dut2 (.out(o2), .clk(clk), .clr(clr), .en(en));
  pc_counter #(.WIDTH(4),  .INCREMENT(4), .RESET_VALUE(0))
    dut3 (.out(o3), .clk(clk), .clr(clr), .en(en));
  pc_counter #(.WIDTH(32), .INCREMENT(1), .RESET_VALUE(64'hFFFF_FFFD))
    dut4 (.out(o4), .clk(clk), .clr(clr), .en(en));
  pc_counter #(.WIDTH(8),  .INCREMENT(3), .RESET_VALUE(5))
    dut5 (.out(o5), .clk(clk), .clr(clr), .en(en));

  always #10 clk = ~clk;

  // Reference model parameters, one entry per instance.
  int unsigned     w_tab   [N] = '{32, 4, 32, 4, 32, 8};
  longint unsigned inc_tab [N] = '{1, 1, 4, 4, 1, 3};
  longint unsigned rv_tab  [N] = '{0, 0, 0, 0, 64'hFFFF_FFFD, 5};

  typedef struct {
    longint unsigned v [N];
    int              cyc;
  } exp_t;

  exp_t            sb_q[$];
  longint unsigned model [N];
  int              total = 0;
  int              bad   = 0;
  int              cyc   = 0;

  function automatic logic [63:0] act_of(int i);
    case (i)
      0:       return {32'd0, o0};
      1:       return {60'd0, o1};
      2:       return {32'd0, o2};
      3:       return {60'd0, o3};
      4:       return {32'd0, o4};
      default: return {56'd0, o5};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge with the given controls; the model follows the counting rules directly.
  task automatic step(input logic c, input logic e);
    exp_t x;
    clr = c;
    en  = e;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      longint unsigned m;
      m = 64'd1 << w_tab[i];
      if (c)      model[i] = rv_tab[i] % m;
      else if (e) model[i] = (model[i] + inc_tab[i]) % m;
      x.v[i] = model[i];
    end
    x.cyc = cyc;
    sb_q.push_back(x);
    $display("cycle %0d clr=%0b en=%0b exp0=%0d exp1=%0d exp2=%0d exp3=%0d exp4=%0h exp5=%0d",
             cyc, c, e, x.v[0], x.v[1], x.v[2], x.v[3], x.v[4], x.v[5]);
    #2;
  endtask

  // Monitor: compares every instance at each falling edge, after inputs changed mid-cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 64'd0, 64'd1);
      end else begin
        x = sb_q.pop_front();
        for (int i = 0; i < N; i++) begin
          chk($sformatf("cyc%0d_dut%0d", x.cyc, i), act_of(i), x.v[i]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) model[i] = rv_tab[i] % (64'd1 << w_tab[i]);
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("initial_dut%0d", i), act_of(i), model[i]);

    // Free run from power-up without clr: 50 edges.
    repeat (50) step(1'b0, 1'b1);
    chk("free_run_50", {32'd0, o0}, 64'd50);

    // Hold: count to 7, pause 5 edges, resume.
    step(1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("hold_resume_8", {32'd0, o0}, 64'd8);

    // Clear at 12, held for 3 more edges, then resume.
    repeat (4) step(1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("clear_resume_1", {32'd0, o0}, 64'd1);

    // clr and en together: clr wins.
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("priority_0", {32'd0, o0}, 64'd0);

    // Randomised controls.
    repeat (400) step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
